// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Byte-serial front end for the 8-bit logic unit. It collects a command byte
// and operand bytes from a valid/ready stream and holds stable operands and
// select on lu_a/lu_b/lu_s. One cycle later it samples the combinational
// result lu_d. The result and its zero/parity flags are offered on a
// valid/ready output stream. A chained command reuses the previous result as A.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] lu_a,
  output logic [7:0] lu_b,
  output logic [1:0] lu_s,
  input  logic [7:0] lu_d,
  output logic [7:0] out_data,
  output logic       out_zero,
  output logic       out_parity,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] op_count
);

  localparam logic [2:0] S_CMD   = 3'd0;
  localparam logic [2:0] S_GET_A = 3'd1;
  localparam logic [2:0] S_GET_B = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0] r_state;
  logic [7:0] r_lu_a;
  logic [7:0] r_lu_b;
  logic [1:0] r_lu_s;
  logic [7:0] r_acc;
  logic [7:0] r_out_data;
  logic       r_out_zero;
  logic       r_out_parity;
  logic [7:0] r_op_count;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_in_xfer;
  logic       w_out_xfer;
  logic       w_cmd_chain;
  logic       w_unused_cmd_bits;

  // Zero flag of a captured result.
  function automatic logic f_zero(input logic [7:0] v);
    return (v == 8'h00);
  endfunction

  // Odd parity of a captured result: 1 when an odd number of bits are set.
  function automatic logic f_parity(input logic [7:0] v);
    return ^v;
  endfunction

  assign w_in_ready  = (r_state == S_CMD) || (r_state == S_GET_A) || (r_state == S_GET_B);
  assign w_out_valid = (r_state == S_OUT);
  assign w_in_xfer   = in_valid && w_in_ready;
  assign w_out_xfer  = w_out_valid && out_ready;
  assign w_cmd_chain = in_data[7];

  // Command bits [6:2] carry no meaning for this block.
  assign w_unused_cmd_bits = ^in_data[6:2];

  // Sequence control: byte collection, execute, output handshake, op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CMD;
      r_op_count <= 8'h00;
    end else begin
      case (r_state)
        S_CMD: begin
          if (w_in_xfer) begin
            r_state <= w_cmd_chain ? S_GET_B : S_GET_A;
          end
        end
        S_GET_A: begin
          if (w_in_xfer) begin
            r_state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (w_in_xfer) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (w_out_xfer) begin
            r_op_count <= r_op_count + 8'd1;
            r_state    <= S_CMD;
          end
        end
        default: begin
          r_state <= S_CMD;
        end
      endcase
    end
  end

  // Operand/select loading and result capture. Operands persist across ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lu_a       <= 8'h00;
      r_lu_b       <= 8'h00;
      r_lu_s       <= 2'b00;
      r_acc        <= 8'h00;
      r_out_data   <= 8'h00;
      r_out_zero   <= 1'b1;
      r_out_parity <= 1'b0;
    end else begin
      case (r_state)
        S_CMD: begin
          if (w_in_xfer) begin
            r_lu_s <= in_data[1:0];
            if (w_cmd_chain) begin
              r_lu_a <= r_acc;
            end
          end
        end
        S_GET_A: begin
          if (w_in_xfer) begin
            r_lu_a <= in_data;
          end
        end
        S_GET_B: begin
          if (w_in_xfer) begin
            r_lu_b <= in_data;
          end
        end
        S_EXEC: begin
          r_out_data   <= lu_d;
          r_acc        <= lu_d;
          r_out_zero   <= f_zero(lu_d);
          r_out_parity <= f_parity(lu_d);
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign lu_a       = r_lu_a;
  assign lu_b       = r_lu_b;
  assign lu_s       = r_lu_s;
  assign out_data   = r_out_data;
  assign out_zero   = r_out_zero;
  assign out_parity = r_out_parity;
  assign op_count   = r_op_count;

endmodule
